mem_access_unit: RTL and testbench

- Sits between the EX/MEM pipeline register and `DataMemory` in the MEM stage.
- Turns one RV64 load/store request into a sequence of whole-doubleword `DataMemory` accesses:
  - read-modify-write for sub-doubleword stores;
  - two-doubleword splitting for accesses that cross a doubleword boundary.
- Byte lanes are extracted, sign- or zero-extended and merged here, so `DataMemory` stays a plain 64-bit array.

---
 rtl/mem_access_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// RV64 load/store sequencer: turns one request into whole-doubleword DataMemory accesses.
// Optional feature macro MEM_ACCESS_MISALIGNED_SPLIT_EN enables splitting of doubleword-crossing accesses.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] address,
   output logic [63:0] writeData,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [63:0] readData
);

   localparam int unsigned XLEN = 64;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      WR0  = 3'd2,
      RESP = 3'd3
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
      ,
      RD1  = 3'd4,
      WR1  = 3'd5
`endif
   } state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      return 4'(4'd1 << sz);
   endfunction

   function automatic logic crosses(input logic [2:0] off, input logic [1:0] sz);
      return (4'({1'b0, off}) + size_bytes(sz)) > 4'd8;
   endfunction

   function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   // Sign- or zero-extend the low size bytes of an already lane-aligned value
   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
      logic s;
      s = ~f3[2];
      case (f3[1:0])
         2'd0:    return {{56{s & d[7]}},  d[7:0]};
         2'd1:    return {{48{s & d[15]}}, d[15:0]};
         2'd2:    return {{32{s & d[31]}}, d[31:0]};
         default: return d;
      endcase
   endfunction

   state_t            r_state;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [2:0]        r_f3;
   logic              r_store;

   logic              w_bad_enc;
   logic              w_req_err;
   logic              w_req_sd_aligned;
   logic [2:0]        w_off;
   logic [5:0]        w_sh;
   logic [XLEN-1:0]   w_dw0;
   logic [XLEN-1:0]   w_bm;
   logic [XLEN-1:0]   w_wdm;
   logic [XLEN-1:0]   w_merge0;
   logic [XLEN-1:0]   w_ld_raw;
   logic [XLEN-1:0]   w_ld_ext;

   assign w_bad_enc = (req_funct3 == 3'b111) | (req_write & req_funct3[2]) | (req_read == req_write);
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
   assign w_req_err = w_bad_enc;
`else
   assign w_req_err = w_bad_enc | crosses(req_addr[2:0], req_funct3[1:0]);
`endif
   assign w_req_sd_aligned = req_write & (req_funct3 == 3'b011) & (req_addr[2:0] == 3'b000);

   assign w_off    = r_addr[2:0];
   assign w_sh     = {w_off, 3'b000};
   assign w_dw0    = {r_addr[XLEN-1:3], 3'b000};
   assign w_bm     = size_mask(r_f3[1:0]);
   assign w_wdm    = r_wdata & w_bm;
   assign w_merge0 = (readData & ~(w_bm << w_sh)) | (w_wdm << w_sh);

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
   logic [XLEN-1:0]   r_dw0;
   logic [6:0]        w_rsh;
   logic [XLEN-1:0]   w_dw1;
   logic [XLEN-1:0]   w_merge1;
   logic              w_cross;

   // Bytes that spill past the first doubleword land at the bottom of the second
   assign w_rsh    = 7'd64 - 7'(w_sh);
   assign w_dw1    = w_dw0 + 64'd8;
   assign w_merge1 = (readData & ~(w_bm >> w_rsh)) | (w_wdm >> w_rsh);
   assign w_cross  = crosses(w_off, r_f3[1:0]);
   assign w_ld_raw = (r_state == RD1) ? ((r_dw0 >> w_sh) | (readData << w_rsh))
                                      : (readData >> w_sh);
`else
   assign w_ld_raw = readData >> w_sh;
`endif
   assign w_ld_ext = extend(w_ld_raw, r_f3);

   // State sequencing; every output is registered against the state being entered
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_f3       <= '0;
         r_store    <= 1'b0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
         r_dw0      <= '0;
`endif
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         MemRead    <= 1'b0;
         MemWrite   <= 1'b0;
         address    <= '0;
         writeData  <= '0;
      end else begin
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         MemRead    <= 1'b0;
         MemWrite   <= 1'b0;
         address    <= '0;
         writeData  <= '0;
         case (r_state)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  r_addr    <= req_addr;
                  r_wdata   <= req_wdata;
                  r_f3      <= req_funct3;
                  r_store   <= req_write;
                  if (w_req_err) begin
                     r_state    <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (w_req_sd_aligned) begin
                     r_state   <= WR0;
                     MemWrite  <= 1'b1;
                     address   <= req_addr;
                     writeData <= req_wdata;
                  end else begin
                     r_state <= RD0;
                     MemRead <= 1'b1;
                     address <= {req_addr[XLEN-1:3], 3'b000};
                  end
               end
            end
            RD0: begin
               if (r_store) begin
                  r_state   <= WR0;
                  MemWrite  <= 1'b1;
                  address   <= w_dw0;
                  writeData <= w_merge0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
               end else if (w_cross) begin
                  r_state <= RD1;
                  r_dw0   <= readData;
                  MemRead <= 1'b1;
                  address <= w_dw1;
`endif
               end else begin
                  r_state    <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= w_ld_ext;
               end
            end
            WR0: begin
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
               if (w_cross) begin
                  r_state <= RD1;
                  MemRead <= 1'b1;
                  address <= w_dw1;
               end else begin
                  r_state    <= RESP;
                  resp_valid <= 1'b1;
               end
`else
               r_state    <= RESP;
               resp_valid <= 1'b1;
`endif
            end
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            RD1: begin
               if (r_store) begin
                  r_state   <= WR1;
                  MemWrite  <= 1'b1;
                  address   <= w_dw1;
                  writeData <= w_merge1;
               end else begin
                  r_state    <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= w_ld_ext;
               end
            end
            WR1: begin
               r_state    <= RESP;
               resp_valid <= 1'b1;
            end
`endif
            RESP: begin
               r_state   <= IDLE;
               req_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table with a response scoreboard, plus reset and back-to-back sequences.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_read = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [63:0] req_addr = 64'h0;
   logic [63:0] req_wdata = 64'h0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic [63:0] address;
   logic [63:0] writeData;
   logic        MemWrite;
   logic        MemRead;
   logic [63:0] readData;

   mem_access_unit dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_read   (req_read),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .address    (address),
      .writeData  (writeData),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .readData   (readData)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic        exp_err;
      int          exp_n;
      int          exp_rd;
      int          exp_wr;
      logic [63:0] exp_last_rd;
      logic [63:0] chk_addr;
      logic [63:0] exp_mem;
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] rdata;
      logic        err;
      int          n;
      int          acc;
   } sb_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   sb_t  sb[$];
   sb_t  e;
   vec_t vecs[19];

   // DataMemory model: 16 doublewords indexed by address[6:3], with strobe bookkeeping
   logic [63:0] mem [16];
   logic        do_init = 1'b0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [63:0] last_rd = 64'h0;
   logic        both_flag = 1'b0;
   logic        bad_align = 1'b0;

   assign readData = mem[address[6:3]];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (do_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 64'h0;
         mem[0]  <= 64'h0011_2233_4455_6677;
         mem[1]  <= 64'hDEAD_BEEF_DEAD_BEEF;
         mem[2]  <= 64'hCAFE_BABE_CAFE_BABE;
         mem[3]  <= 64'h0123_4567_89AB_CDEF;
         mem[15] <= 64'h8899_AABB_CCDD_EEFF;
         rd_cnt  <= 0;
         wr_cnt  <= 0;
         last_rd <= 64'h0;
      end else begin
         if (MemWrite) begin
            mem[address[6:3]] <= writeData;
            wr_cnt <= wr_cnt + 1;
         end
         if (MemRead) begin
            rd_cnt  <= rd_cnt + 1;
            last_rd <= address;
         end
         if (MemRead && MemWrite) both_flag <= 1'b1;
         if ((MemRead || MemWrite) && address[2:0] != 3'b000) bad_align <= 1'b1;
      end
   end

   task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard consumer: every response pops the oldest expected result
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata %h err %0b expected no response", resp_rdata, resp_err);
         end else begin
            e = sb.pop_front();
            check64({e.name, "_rdata"}, resp_rdata, e.rdata);
            check64({e.name, "_err"}, 64'(resp_err), 64'(e.err));
            check64({e.name, "_latency"}, 64'(cyc - e.acc + 1), 64'(e.n));
         end
      end
   end

   task automatic mem_init();
      @(negedge clk);
      do_init = 1'b1;
      @(posedge clk);
      #1 do_init = 1'b0;
   endtask

   task automatic issue(input vec_t v);
      bit ok;
      ok         = 1'b0;
      req_read   = v.rd;
      req_write  = v.wr;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_valid  = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s_accept: req_ready stayed %0b expected 1", v.name, req_ready);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      sb.push_back('{v.name, v.exp_rdata, v.exp_err, v.exp_n, cyc});
   endtask

   task automatic drain(input string nm);
      int i;
      i = 0;
      while (sb.size() != 0 && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d responses outstanding expected 0", nm, sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //                name       rd    wr    f3      addr                    wdata                   exp_rdata                                              err    n            rd           wr           last_rd      chk_addr     exp_mem
      vecs[0]  = '{"LD_8",    1'b1, 1'b0, 3'b011, 64'h8,                  64'h0,                  64'hDEAD_BEEF_DEAD_BEEF,                               1'b0,  2,           1,           0,           64'h8,       64'h8,       64'hDEAD_BEEF_DEAD_BEEF};
      vecs[1]  = '{"LB_B",    1'b1, 1'b0, 3'b000, 64'hB,                  64'h0,                  64'hFFFF_FFFF_FFFF_FFDE,                               1'b0,  2,           1,           0,           64'h8,       64'h8,       64'hDEAD_BEEF_DEAD_BEEF};
      vecs[2]  = '{"LBU_B",   1'b1, 1'b0, 3'b100, 64'hB,                  64'h0,                  64'h0000_0000_0000_00DE,                               1'b0,  2,           1,           0,           64'h8,       64'h8,       64'hDEAD_BEEF_DEAD_BEEF};
      vecs[3]  = '{"LH_12",   1'b1, 1'b0, 3'b001, 64'h12,                 64'h0,                  64'hFFFF_FFFF_FFFF_CAFE,                               1'b0,  2,           1,           0,           64'h10,      64'h10,      64'hCAFE_BABE_CAFE_BABE};
      vecs[4]  = '{"LWU_1C",  1'b1, 1'b0, 3'b110, 64'h1C,                 64'h0,                  64'h0000_0000_0123_4567,                               1'b0,  2,           1,           0,           64'h18,      64'h18,      64'h0123_4567_89AB_CDEF};
      vecs[5]  = '{"LW_18",   1'b1, 1'b0, 3'b010, 64'h18,                 64'h0,                  64'hFFFF_FFFF_89AB_CDEF,                               1'b0,  2,           1,           0,           64'h18,      64'h18,      64'h0123_4567_89AB_CDEF};
      vecs[6]  = '{"LHU_16",  1'b1, 1'b0, 3'b101, 64'h16,                 64'h0,                  64'h0000_0000_0000_CAFE,                               1'b0,  2,           1,           0,           64'h10,      64'h10,      64'hCAFE_BABE_CAFE_BABE};
      vecs[7]  = '{"SH_10",   1'b0, 1'b1, 3'b001, 64'h10,                 64'hAAAA_AAAA_AAAA_1234, 64'h0,                                                1'b0,  3,           1,           1,           64'h10,      64'h10,      64'hCAFE_BABE_CAFE_1234};
      vecs[8]  = '{"SD_18",   1'b0, 1'b1, 3'b011, 64'h18,                 64'h1122_3344_5566_7788, 64'h0,                                                1'b0,  2,           0,           1,           64'h0,       64'h18,      64'h1122_3344_5566_7788};
      vecs[9]  = '{"SB_D",    1'b0, 1'b1, 3'b000, 64'hD,                  64'hFFFF_FFFF_FFFF_FF5A, 64'h0,                                                1'b0,  3,           1,           1,           64'h8,       64'h8,       64'hDEAD_5AEF_DEAD_BEEF};
      vecs[10] = '{"SW_14",   1'b0, 1'b1, 3'b010, 64'h14,                 64'hFFFF_FFFF_89AB_CDEF, 64'h0,                                                1'b0,  3,           1,           1,           64'h10,      64'h10,      64'h89AB_CDEF_CAFE_BABE};
      vecs[11] = '{"LW_E_X",  1'b1, 1'b0, 3'b010, 64'hE,                  64'h0,                  SPLIT ? 64'hFFFF_FFFF_BABE_DEAD : 64'h0,                !SPLIT, SPLIT ? 3 : 1, SPLIT ? 2 : 0, 0,           64'h10,      64'h10,      64'hCAFE_BABE_CAFE_BABE};
      vecs[12] = '{"SD_C_X",  1'b0, 1'b1, 3'b011, 64'hC,                  64'h0102_0304_0506_0708, 64'h0,                                                !SPLIT, SPLIT ? 5 : 1, SPLIT ? 2 : 0, SPLIT ? 2 : 0, 64'h10,   64'h10,      SPLIT ? 64'hCAFE_BABE_0102_0304 : 64'hCAFE_BABE_CAFE_BABE};
      vecs[13] = '{"LH_WRAP", 1'b1, 1'b0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  SPLIT ? 64'h0000_0000_0000_7788 : 64'h0,                !SPLIT, SPLIT ? 3 : 1, SPLIT ? 2 : 0, 0,           64'h0,       64'h0,       64'h0011_2233_4455_6677};
      vecs[14] = '{"ILL_111", 1'b1, 1'b0, 3'b111, 64'h8,                  64'h0,                  64'h0,                                                 1'b1,  1,           0,           0,           64'h0,       64'h8,       64'hDEAD_BEEF_DEAD_BEEF};
      vecs[15] = '{"SBU_ST",  1'b0, 1'b1, 3'b100, 64'h10,                 64'hFF,                 64'h0,                                                 1'b1,  1,           0,           0,           64'h0,       64'h10,      64'hCAFE_BABE_CAFE_BABE};
      vecs[16] = '{"RW_BOTH", 1'b1, 1'b1, 3'b011, 64'h8,                  64'h0123_4567_0123_4567, 64'h0,                                                1'b1,  1,           0,           0,           64'h0,       64'h8,       64'hDEAD_BEEF_DEAD_BEEF};
      vecs[17] = '{"RW_NONE", 1'b0, 1'b0, 3'b000, 64'h8,                  64'h0,                  64'h0,                                                 1'b1,  1,           0,           0,           64'h0,       64'h8,       64'hDEAD_BEEF_DEAD_BEEF};
      vecs[18] = '{"SB_17",   1'b0, 1'b1, 3'b000, 64'h17,                 64'h0000_0000_0000_0099, 64'h0,                                                1'b0,  3,           1,           1,           64'h10,      64'h10,      64'h99FE_BABE_CAFE_BABE};

      // Reset state
      repeat (2) @(posedge clk);
      mem_init();
      #2;
      check64("rst_ready", 64'(req_ready), 64'h0);
      check64("rst_strobes", 64'({resp_valid, resp_err, MemRead, MemWrite}), 64'h0);
      check64("rst_rdata", resp_rdata, 64'h0);
      check64("rst_address", address, 64'h0);
      check64("rst_writedata", writeData, 64'h0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 check64("rst_release_ready", 64'(req_ready), 64'h1);

      // Vector table
      for (int k = 0; k < 19; k++) begin
         mem_init();
         issue(vecs[k]);
         drain(vecs[k].name);
         check64({vecs[k].name, "_mem"}, mem[vecs[k].chk_addr[6:3]], vecs[k].exp_mem);
         check64({vecs[k].name, "_nread"}, 64'(rd_cnt), 64'(vecs[k].exp_rd));
         check64({vecs[k].name, "_nwrite"}, 64'(wr_cnt), 64'(vecs[k].exp_wr));
         if (vecs[k].exp_rd > 0)
            check64({vecs[k].name, "_last_rd_addr"}, last_rd, vecs[k].exp_last_rd);
      end

      // Back-to-back requests, next one held valid while the block is busy
      mem_init();
      issue(vecs[0]);
      issue(vecs[2]);
      issue(vecs[7]);
      drain("b2b");
      check64("b2b_mem", mem[2], 64'hCAFE_BABE_CAFE_1234);
      check64("b2b_nwrite", 64'(wr_cnt), 64'h1);

      // Reset pulled low during RD0 of a byte store
      mem_init();
      req_read   = 1'b0;
      req_write  = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 64'h10;
      req_wdata  = 64'h77;
      req_valid  = 1'b1;
      begin
         bit ok;
         ok = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
               ok = 1'b1;
               break;
            end
         end
         check64("midrst_accept", 64'(ok), 64'h1);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      check64("midrst_rd0_memread", 64'(MemRead), 64'h1);
      #1 reset = 1'b0;
      #1;
      check64("midrst_strobes", 64'({resp_valid, resp_err, MemRead, MemWrite, req_ready}), 64'h0);
      check64("midrst_rdata", resp_rdata, 64'h0);
      check64("midrst_address", address, 64'h0);
      check64("midrst_writedata", writeData, 64'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 check64("midrst_ready_after_release", 64'(req_ready), 64'h1);
      repeat (3) @(negedge clk);
      check64("midrst_nwrite", 64'(wr_cnt), 64'h0);
      check64("midrst_mem", mem[2], 64'hCAFE_BABE_CAFE_BABE);

      check64("strobe_exclusive", 64'(both_flag), 64'h0);
      check64("strobe_dw_aligned", 64'(bad_align), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
